fme_satd_select: RTL and testbench

//   Downstream of the 4x4 Hadamard SATD processing unit in the FME path.
//   Per candidate, sums NBLK 4x4 SATD results into a partition cost.

---
 rtl/fme_pkg.sv | 44 ++++
 rtl/fme_sat_acc.sv | 33 +++
 rtl/fme_satd_select.sv | 160 ++++++++++++++++
 tb/tb_fme_satd_select.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fme_pkg.sv
// +--------------------------------------------------------------------------+
// | Module  : fme_pkg                                                        |
// | Brief   : Shared constants, FSM state type and grid helper for the FME   |
// |           SATD candidate selector.                                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package fme_pkg;

  localparam int FME_NCAND  = 9;
  localparam int FME_NBLK   = 16;
  localparam int FME_SATD_W = 16;
  localparam int FME_ACC_W  = 20;

  localparam logic [3:0] CENTRE_IDX = 4'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } fme_sel_state_t;

  // Manhattan distance of a 3x3 half-pel grid position from the centre.
  function automatic logic [1:0] cand_dist(input logic [3:0] idx);
    logic [3:0] col;
    logic [3:0] row;
    logic [1:0] dc;
    logic [1:0] dr;
    col = idx % 4'd3;
    row = idx / 4'd3;
    dc  = (col == 4'd1) ? 2'd0 : 2'd1;
    dr  = (row == 4'd1) ? 2'd0 : 2'd1;
    if (idx == CENTRE_IDX) begin
      return 2'd0;
    end
    return dc + dr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fme_sat_acc.sv
// +--------------------------------------------------------------------------+
// | Module  : fme_sat_acc                                                    |
// | Brief   : Combinational saturating W-bit adder with synchronous-use clear.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fme_sat_acc #(
  parameter int W = 20
) (
  input  logic         clr_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] w_full;

  assign w_full = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    sum_o = w_full[W-1:0];
    if (clr_i) begin
      sum_o = '0;
    end else if (w_full[W]) begin
      sum_o = {W{1'b1}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fme_satd_select.sv
// +--------------------------------------------------------------------------+
// | Module  : fme_satd_select                                                |
// | Brief   : Sums NBLK 4x4 SATD beats per FME candidate and reports the     |
// |           lowest-cost candidate. Define FME_MVCOST_EN to add the         |
// |           lambda-weighted MV distance penalty to each cost.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fme_satd_select
  import fme_pkg::*;
#(
  parameter int NCAND  = FME_NCAND,
  parameter int NBLK   = FME_NBLK,
  parameter int SATD_W = FME_SATD_W,
  parameter int ACC_W  = FME_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              satd_valid,
  output logic              satd_ready,
  input  logic [SATD_W-1:0] satd_in,
  input  logic [7:0]        lambda,
  output logic              busy,
  output logic              done,
  output logic [3:0]        best_idx,
  output logic [ACC_W-1:0]  best_cost
);

  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  fme_sel_state_t   state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] best_cost_q, best_cost_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [3:0]       cand_cnt_q, cand_cnt_d;
  logic [3:0]       best_idx_q, best_idx_d;

  logic             w_acc_clr;
  logic             w_beat;
  logic [ACC_W-1:0] w_satd_ext;
  logic [ACC_W-1:0] w_acc_sum;
  logic [ACC_W-1:0] w_cost;

  assign w_satd_ext = ACC_W'(satd_in);

  fme_sat_acc #(.W(ACC_W)) u_acc (
    .clr_i (w_acc_clr),
    .a_i   (acc_q),
    .b_i   (w_satd_ext),
    .sum_o (w_acc_sum)
  );

`ifdef FME_MVCOST_EN
  logic [9:0]       w_pen;
  logic [ACC_W-1:0] w_pen_ext;

  assign w_pen     = {2'b00, lambda} * {8'd0, cand_dist(cand_cnt_q)};
  assign w_pen_ext = ACC_W'(w_pen);

  fme_sat_acc #(.W(ACC_W)) u_pen (
    .clr_i (1'b0),
    .a_i   (acc_q),
    .b_i   (w_pen_ext),
    .sum_o (w_cost)
  );
`else
  logic w_unused_lambda;

  assign w_unused_lambda = ^lambda;
  assign w_cost          = acc_q;
`endif

  always_comb begin
    state_d     = state_q;
    blk_cnt_d   = blk_cnt_q;
    cand_cnt_d  = cand_cnt_q;
    best_idx_d  = best_idx_q;
    best_cost_d = best_cost_q;
    w_acc_clr   = 1'b0;
    w_beat      = 1'b0;
    satd_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          w_acc_clr  = 1'b1;
          blk_cnt_d  = '0;
          cand_cnt_d = '0;
        end
      end
      ACCUM: begin
        satd_ready = 1'b1;
        busy       = 1'b1;
        if (satd_valid) begin
          w_beat    = 1'b1;
          blk_cnt_d = blk_cnt_q + 1'b1;
          if (blk_cnt_q == BLK_W'(NBLK - 1)) begin
            blk_cnt_d = '0;
            state_d   = COMPARE;
          end
        end
      end
      COMPARE: begin
        busy = 1'b1;
        // Strict less-than: on a tie the earlier (lower) index is kept.
        if ((cand_cnt_q == 4'd0) || (w_cost < best_cost_q)) begin
          best_idx_d  = cand_cnt_q;
          best_cost_d = w_cost;
        end
        if (cand_cnt_q == 4'(NCAND - 1)) begin
          state_d = DONE;
        end else begin
          cand_cnt_d = cand_cnt_q + 4'd1;
          w_acc_clr  = 1'b1;
          blk_cnt_d  = '0;
          state_d    = ACCUM;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign acc_d = (w_acc_clr || w_beat) ? w_acc_sum : acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      blk_cnt_q   <= '0;
      cand_cnt_q  <= '0;
      best_idx_q  <= '0;
      best_cost_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      blk_cnt_q   <= blk_cnt_d;
      cand_cnt_q  <= cand_cnt_d;
      best_idx_q  <= best_idx_d;
      best_cost_q <= best_cost_d;
    end
  end

  assign best_idx  = best_idx_q;
  assign best_cost = best_cost_q;

endmodule

`default_nettype wire

// File: tb/tb_fme_satd_select.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_fme_satd_select                                             |
// | Brief   : Directed self-checking bench for fme_satd_select; a second     |
// |           18-bit-cost instance shares the stimulus to expose saturation. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fme_satd_select;

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic        start      = 1'b0;
  logic        satd_valid = 1'b0;
  logic [15:0] satd_in    = 16'd0;
  logic [7:0]  lambda     = 8'd0;

  wire         satd_ready;
  wire         busy;
  wire         done;
  wire  [3:0]  best_idx;
  wire  [19:0] best_cost;

  wire         unused_s_ready;
  wire         unused_s_busy;
  wire         unused_s_done;
  wire  [3:0]  s_idx;
  wire  [17:0] s_cost;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] cand_val [9];
  int          last_cyc;
  int          done_cyc;
  int          ready_hi_after_last;
  bit          drive_timeout;

  fme_satd_select u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .satd_valid (satd_valid),
    .satd_ready (satd_ready),
    .satd_in    (satd_in),
    .lambda     (lambda),
    .busy       (busy),
    .done       (done),
    .best_idx   (best_idx),
    .best_cost  (best_cost)
  );

  fme_satd_select #(.ACC_W(18)) u_dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .satd_valid (satd_valid),
    .satd_ready (unused_s_ready),
    .satd_in    (satd_in),
    .lambda     (lambda),
    .busy       (unused_s_busy),
    .done       (unused_s_done),
    .best_idx   (s_idx),
    .best_cost  (s_cost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Runs one full round from IDLE; beats of candidate k all carry cand_val[k].
  task automatic drive_round(input int gap_pct, input bit poke_start);
    int  cand;
    int  blk;
    int  guard;
    bit  prev_last;
    cand = 0;
    blk = 0;
    guard = 0;
    prev_last = 1'b0;
    ready_hi_after_last = 0;
    last_cyc = -1;
    drive_timeout = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cand < 9) begin
      if (prev_last && satd_ready) ready_hi_after_last++;
      prev_last = 1'b0;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        satd_valid = 1'b0;
        satd_in    = 16'hDEAD;
        start      = poke_start && ($urandom_range(1) == 1);
      end else begin
        satd_valid = 1'b1;
        satd_in    = cand_val[cand];
        start      = 1'b0;
        if (satd_ready) begin
          if (blk == 15) begin
            blk = 0;
            cand++;
            prev_last = 1'b1;
            last_cyc = cyc;
          end else begin
            blk++;
          end
        end
      end
      @(negedge clk);
      guard++;
      if (guard > 4000) begin
        drive_timeout = 1'b1;
        break;
      end
    end
    satd_valid = 1'b0;
    start      = 1'b0;
    if (prev_last && satd_ready) ready_hi_after_last++;
  endtask

  task automatic wait_done();
    done_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (satd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", satd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (best_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", best_idx); end
    n_checks++; if (best_cost !== 20'd0) begin n_fail++; $display("FAIL reset_cost: got %0d want 0", best_cost); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start_busy: got %b want 0", busy); end
  endtask

  task automatic test_min_candidate();
    for (int i = 0; i < 9; i++) cand_val[i] = 16'd10;
    cand_val[7] = 16'd9;
    drive_round(0, 1'b0);
    wait_done();
    n_checks++; if (drive_timeout || done_cyc < 0) begin n_fail++; $display("FAIL min_timeout: got done_cyc=%0d want done seen", done_cyc); end
    n_checks++; if (done_cyc - last_cyc !== 2) begin n_fail++; $display("FAIL min_latency: got %0d want 2", done_cyc - last_cyc); end
    n_checks++; if (best_idx !== 4'd7) begin n_fail++; $display("FAIL min_idx: got %0d want 7", best_idx); end
    n_checks++; if (best_cost !== 20'd144) begin n_fail++; $display("FAIL min_cost: got %0d want 144", best_cost); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL min_busy_at_done: got %b want 0", busy); end
    n_checks++; if (ready_hi_after_last !== 0) begin n_fail++; $display("FAIL min_ready_in_compare: got %0d want 0", ready_hi_after_last); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL min_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_reset_mid_round();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      satd_valid = 1'b1;
      satd_in    = 16'd50;
      @(negedge clk);
    end
    satd_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (satd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", satd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_checks++; if (best_cost !== 20'd0) begin n_fail++; $display("FAIL mid_rst_cost: got %0d want 0", best_cost); end
    n_checks++; if (best_idx !== 4'd0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d want 0", best_idx); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ties();
    for (int i = 0; i < 9; i++) cand_val[i] = 16'd100;
    drive_round(0, 1'b0);
    wait_done();
    n_checks++; if (drive_timeout || done_cyc < 0) begin n_fail++; $display("FAIL tie_timeout: got done_cyc=%0d want done seen", done_cyc); end
    n_checks++; if (best_idx !== 4'd0) begin n_fail++; $display("FAIL tie_idx: got %0d want 0", best_idx); end
    n_checks++; if (best_cost !== 20'd1600) begin n_fail++; $display("FAIL tie_cost: got %0d want 1600", best_cost); end
    repeat (3) @(negedge clk);
    n_checks++; if (best_cost !== 20'd1600) begin n_fail++; $display("FAIL tie_hold: got %0d want 1600", best_cost); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) cand_val[i] = 16'd0;
    cand_val[0] = 16'hFFFF;
    drive_round(0, 1'b0);
    wait_done();
    n_checks++; if (best_idx !== 4'd1) begin n_fail++; $display("FAIL sat0_idx: got %0d want 1", best_idx); end
    n_checks++; if (best_cost !== 20'd0) begin n_fail++; $display("FAIL sat0_cost: got %0d want 0", best_cost); end
    n_checks++; if (s_idx !== 4'd1) begin n_fail++; $display("FAIL sat0_narrow_idx: got %0d want 1", s_idx); end
    for (int i = 0; i < 9; i++) cand_val[i] = 16'hFFFF;
    drive_round(0, 1'b0);
    wait_done();
    n_checks++; if (best_idx !== 4'd0) begin n_fail++; $display("FAIL satall_idx: got %0d want 0", best_idx); end
    n_checks++; if (best_cost !== 20'hFFFF0) begin n_fail++; $display("FAIL satall_cost: got %h want FFFF0", best_cost); end
    n_checks++; if (s_cost !== 18'h3FFFF) begin n_fail++; $display("FAIL satall_narrow_cost: got %h want 3FFFF", s_cost); end
    n_checks++; if (s_idx !== 4'd0) begin n_fail++; $display("FAIL satall_narrow_idx: got %0d want 0", s_idx); end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 9; i++) cand_val[i] = 16'd10;
    cand_val[7] = 16'd9;
    drive_round(50, 1'b1);
    wait_done();
    n_checks++; if (drive_timeout || done_cyc < 0) begin n_fail++; $display("FAIL gap_timeout: got done_cyc=%0d want done seen", done_cyc); end
    n_checks++; if (done_cyc - last_cyc !== 2) begin n_fail++; $display("FAIL gap_latency: got %0d want 2", done_cyc - last_cyc); end
    n_checks++; if (best_idx !== 4'd7) begin n_fail++; $display("FAIL gap_idx: got %0d want 7", best_idx); end
    n_checks++; if (best_cost !== 20'd144) begin n_fail++; $display("FAIL gap_cost: got %0d want 144", best_cost); end
    n_checks++; if (ready_hi_after_last !== 0) begin n_fail++; $display("FAIL gap_ready_in_compare: got %0d want 0", ready_hi_after_last); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_busy: got %b want 0", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_busy2: got %b want 0", busy); end
  endtask

  task automatic test_mvcost();
    for (int i = 0; i < 9; i++) cand_val[i] = 16'd1;
    cand_val[0] = 16'd0;
`ifdef FME_MVCOST_EN
    lambda = 8'd8;
    drive_round(0, 1'b0);
    wait_done();
    n_checks++; if (best_idx !== 4'd0) begin n_fail++; $display("FAIL mv8_idx: got %0d want 0", best_idx); end
    n_checks++; if (best_cost !== 20'd16) begin n_fail++; $display("FAIL mv8_cost: got %0d want 16", best_cost); end
    lambda = 8'd9;
    drive_round(0, 1'b0);
    wait_done();
    n_checks++; if (best_idx !== 4'd4) begin n_fail++; $display("FAIL mv9_idx: got %0d want 4", best_idx); end
    n_checks++; if (best_cost !== 20'd16) begin n_fail++; $display("FAIL mv9_cost: got %0d want 16", best_cost); end
`else
    lambda = 8'd9;
    drive_round(0, 1'b0);
    wait_done();
    n_checks++; if (best_idx !== 4'd0) begin n_fail++; $display("FAIL nomv_idx: got %0d want 0", best_idx); end
    n_checks++; if (best_cost !== 20'd0) begin n_fail++; $display("FAIL nomv_cost: got %0d want 0", best_cost); end
`endif
    lambda = 8'd0;
  endtask

  initial begin
    test_reset();
    test_min_candidate();
    test_reset_mid_round();
    test_ties();
    test_saturation();
    test_gaps();
    test_mvcost();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
